// File: rtl/soc_system_cpu_dct_packer_if.sv
// Fragment/word channel of the OCI DCT trace packer: fragment input, flush,
// accumulator monitor outputs and the valid/ready word slot.
interface soc_system_cpu_dct_packer_if #(
  parameter int unsigned FRAG_W = 3,
  parameter int unsigned FRAGS  = 10,
  parameter int unsigned CNT_W  = 4
);
  localparam int unsigned BUF_W = FRAG_W * FRAGS;

  logic              frag_valid;
  logic [FRAG_W-1:0] frag_data;
  logic              frag_ready;
  logic              flush;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              word_valid;
  logic [BUF_W-1:0]  word_data;
  logic [CNT_W-1:0]  word_count;
  logic              word_ready;
  logic              overflow;

  modport master (
    output frag_valid, frag_data, flush, word_ready,
    input  frag_ready, dct_buffer, dct_count, word_valid, word_data, word_count, overflow
  );

  modport slave (
    input  frag_valid, frag_data, flush, word_ready,
    output frag_ready, dct_buffer, dct_count, word_valid, word_data, word_count, overflow
  );
endinterface

// File: rtl/soc_system_cpu_dct_packer.sv
// Packs 3-bit trace fragments into a 30-bit accumulator and hands full or
// flushed words to the drain side through a single valid/ready output slot.
module soc_system_cpu_dct_packer #(
  parameter int unsigned FRAG_W = 3,
  parameter int unsigned FRAGS  = 10,
  parameter int unsigned CNT_W  = 4
) (
  input logic                         clk,
  input logic                         reset_n,
  soc_system_cpu_dct_packer_if.slave  bus
);
  localparam int unsigned      BUF_W    = FRAG_W * FRAGS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAGS);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;
  logic             r_word_valid;
  logic [BUF_W-1:0] r_word_data;
  logic [CNT_W-1:0] r_word_count;
  logic             r_overflow;
  logic             r_flush_pend;

  logic             w_full;
  logic             w_slot_free;
  logic             w_flush_req;
  logic             w_xfer;
  logic             w_frag_ready;
  logic             w_accept;
  logic [BUF_W-1:0] w_base_buf;
  logic [CNT_W-1:0] w_base_cnt;

  assign w_full       = (r_cnt == FULL_CNT);
  assign w_slot_free  = !r_word_valid || bus.word_ready;
  assign w_flush_req  = (r_flush_pend || bus.flush) && (r_cnt != '0);
  assign w_xfer       = w_slot_free && (w_full || w_flush_req);
  // A full accumulator still takes a fragment in the cycle it is handed off.
  assign w_frag_ready = !w_full || w_xfer;
  assign w_accept     = bus.frag_valid && w_frag_ready;
  assign w_base_buf   = w_xfer ? '0 : r_buf;
  assign w_base_cnt   = w_xfer ? '0 : r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf        <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
      r_word_data  <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_word_valid <= 1'b1;
        r_word_data  <= r_buf;
        r_word_count <= r_cnt;
      end else if (bus.word_ready) begin
        r_word_valid <= 1'b0;
      end

      if (w_accept) begin
        r_buf <= {w_base_buf[BUF_W-FRAG_W-1:0], bus.frag_data};
        r_cnt <= w_base_cnt + CNT_W'(1);
      end else begin
        r_buf <= w_base_buf;
        r_cnt <= w_base_cnt;
      end

      // A flush that cannot hand off now is remembered until the slot frees.
      if (w_xfer) begin
        r_flush_pend <= 1'b0;
      end else if (bus.flush && (r_cnt != '0)) begin
        r_flush_pend <= 1'b1;
      end

      if (bus.frag_valid && !w_frag_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.frag_ready = w_frag_ready;
  assign bus.dct_buffer = r_buf;
  assign bus.dct_count  = r_cnt;
  assign bus.word_valid = r_word_valid;
  assign bus.word_data  = r_word_data;
  assign bus.word_count = r_word_count;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_soc_system_cpu_dct_packer.sv
// Scoreboard bench for the DCT packer: directed fragment streams push expected
// words into a queue that a negedge monitor pops on every word handshake.
module tb_soc_system_cpu_dct_packer;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [33:0] exp_q[$];

  soc_system_cpu_dct_packer_if bus_if ();

  soc_system_cpu_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one fragment only while the packer can take it.
  task automatic send(input logic [2:0] d);
    int k;
    k = 0;
    bus_if.frag_data = d;
    #1;
    while (!bus_if.frag_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("send_timeout", 32'(k), 32'd0);
    bus_if.frag_valid = 1'b1;
    tick();
    bus_if.frag_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [2:0] d);
    for (int i = 0; i < n; i++) send(d);
  endtask

  task automatic push_word(input logic [29:0] data, input logic [3:0] cnt);
    exp_q.push_back({data, cnt});
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    if (reset_n && bus_if.word_valid && bus_if.word_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {2'b0, bus_if.word_data}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", {2'b0, bus_if.word_data}, {2'b0, e[33:4]});
        chk("word_count", {28'd0, bus_if.word_count}, {28'd0, e[3:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus_if.frag_valid = 1'b0;
    bus_if.frag_data  = '0;
    bus_if.flush      = 1'b0;
    bus_if.word_ready = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_buffer", {2'b0, bus_if.dct_buffer}, 32'd0);
    chk("rst_count", {28'd0, bus_if.dct_count}, 32'd0);
    chk("rst_word_valid", {31'd0, bus_if.word_valid}, 32'd0);
    chk("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    chk("rst_frag_ready", {31'd0, bus_if.frag_ready}, 32'd1);

    // 1) ten fragments of 3'b101 with the drain always ready
    bus_if.word_ready = 1'b1;
    push_word(30'h2DB6DB6D, 4'd10);
    send_n(10, 3'b101);
    chk("t1_count_full", {28'd0, bus_if.dct_count}, 32'd10);
    tick();
    chk("t1_word_valid", {31'd0, bus_if.word_valid}, 32'd1);
    chk("t1_count_clear", {28'd0, bus_if.dct_count}, 32'd0);
    tick();
    chk("t1_word_valid_1cyc", {31'd0, bus_if.word_valid}, 32'd0);

    // 2) partial word via flush
    send(3'd1);
    send(3'd2);
    send(3'd3);
    chk("t2_buffer", {2'b0, bus_if.dct_buffer}, 32'h053);
    push_word(30'h053, 4'd3);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    chk("t2_count_clear", {28'd0, bus_if.dct_count}, 32'd0);
    chk("t2_word_valid", {31'd0, bus_if.word_valid}, 32'd1);
    tick();

    // 3) drain stalled for twenty fragments
    bus_if.word_ready = 1'b0;
    push_word(30'h12492492, 4'd10);
    push_word(30'h36DB6DB6, 4'd10);
    send_n(10, 3'b010);
    send_n(10, 3'b110);
    chk("t3_frag_ready", {31'd0, bus_if.frag_ready}, 32'd0);
    chk("t3_count_full", {28'd0, bus_if.dct_count}, 32'd10);
    chk("t3_word_held", {2'b0, bus_if.word_data}, 32'h12492492);
    bus_if.word_ready = 1'b1;
    tick();
    chk("t3_second_word", {2'b0, bus_if.word_data}, 32'h36DB6DB6);
    chk("t3_second_valid", {31'd0, bus_if.word_valid}, 32'd1);
    chk("t3_no_overflow", {31'd0, bus_if.overflow}, 32'd0);
    tick();

    // 4) overflow on a fragment offered while full
    bus_if.word_ready = 1'b0;
    push_word(30'h09249249, 4'd10);
    push_word(30'h1B6DB6DB, 4'd10);
    send_n(10, 3'b001);
    send_n(10, 3'b011);
    bus_if.frag_valid = 1'b1;
    bus_if.frag_data  = 3'b111;
    tick();
    bus_if.frag_valid = 1'b0;
    chk("t4_overflow", {31'd0, bus_if.overflow}, 32'd1);
    chk("t4_buffer_kept", {2'b0, bus_if.dct_buffer}, 32'h1B6DB6DB);
    chk("t4_count_kept", {28'd0, bus_if.dct_count}, 32'd10);
    repeat (3) tick();
    chk("t4_overflow_sticky", {31'd0, bus_if.overflow}, 32'd1);
    bus_if.word_ready = 1'b1;
    repeat (3) tick();
    chk("t4_overflow_after_drain", {31'd0, bus_if.overflow}, 32'd1);

    // 5) flush with a same-cycle fragment
    send(3'b100);
    send(3'b001);
    send(3'b010);
    send(3'b011);
    push_word(30'h853, 4'd4);
    bus_if.flush      = 1'b1;
    bus_if.frag_valid = 1'b1;
    bus_if.frag_data  = 3'b111;
    tick();
    bus_if.flush      = 1'b0;
    bus_if.frag_valid = 1'b0;
    chk("t5_count", {28'd0, bus_if.dct_count}, 32'd1);
    chk("t5_buffer", {2'b0, bus_if.dct_buffer}, 32'h7);
    chk("t5_word_count", {28'd0, bus_if.word_count}, 32'd4);
    tick();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    push_word(30'h7, 4'd1);
    tick();

    // 6) asynchronous reset mid-word with a held word in the slot
    bus_if.word_ready = 1'b0;
    send(3'b110);
    send(3'b101);
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    send_n(7, 3'b011);
    chk("t6_count_pre", {28'd0, bus_if.dct_count}, 32'd7);
    chk("t6_valid_pre", {31'd0, bus_if.word_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_buffer", {2'b0, bus_if.dct_buffer}, 32'd0);
    chk("t6_rst_count", {28'd0, bus_if.dct_count}, 32'd0);
    chk("t6_rst_word_valid", {31'd0, bus_if.word_valid}, 32'd0);
    chk("t6_rst_word_data", {2'b0, bus_if.word_data}, 32'd0);
    chk("t6_rst_word_count", {28'd0, bus_if.word_count}, 32'd0);
    chk("t6_rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    tick();
    reset_n = 1'b1;
    bus_if.word_ready = 1'b1;
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_no_word", {31'd0, bus_if.word_valid}, 32'd0);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
